// File: rtl/mult_control.sv
// Sequencing controller for the 8x8 shift-add multiplier: walks one product
// through CLR, LSB, MID(x2), MSB and DONE, driving accumulator strobes and
// nibble/shift selects.
// Ports: clk, reset_a (async, active-high), start (level request);
//        clk_ena, sclr_n, input_sel[1:0], shift_sel[1:0], state_out[2:0],
//        done_flag; seg_out[6:0] only when MULT_CTRL_SEG_EN is defined.
// Optional feature macro: MULT_CTRL_SEG_EN (active-low gfedcba state digit).
module mult_control (
  input  logic       clk,
  input  logic       reset_a,
  input  logic       start,
  output logic       clk_ena,
  output logic       sclr_n,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic [2:0] state_out,
  output logic       done_flag
`ifdef MULT_CTRL_SEG_EN
  ,
  output logic [6:0] seg_out
`endif
);

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_CLR  = 3'b001;
  localparam logic [2:0] ST_LSB  = 3'b010;
  localparam logic [2:0] ST_MID  = 3'b011;
  localparam logic [2:0] ST_MSB  = 3'b100;
  localparam logic [2:0] ST_DONE = 3'b101;

  logic [2:0] state_q, state_d;
  // Sub-step inside MID: 0 = a_hi*b_lo, 1 = a_lo*b_hi (both use <<4).
  logic       cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= ST_IDLE;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. start is only looked at in IDLE and DONE, so a
  // sequence in flight always runs to completion.
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = start ? ST_CLR : ST_IDLE;
      ST_CLR:  state_d = ST_LSB;
      ST_LSB:  state_d = ST_MID;
      ST_MID: begin
        if (!cnt_q) begin
          state_d = ST_MID;
          cnt_d   = 1'b1;
        end else begin
          state_d = ST_MSB;
        end
      end
      ST_MSB:  state_d = ST_DONE;
      // Holding in DONE while start stays high gives one multiply per request.
      ST_DONE: state_d = start ? ST_DONE : ST_IDLE;
      default: state_d = ST_IDLE;  // 110/111 recover to IDLE
    endcase
  end

  // Moore output decode from state and cnt only
  always_comb begin
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    input_sel = 2'b00;
    shift_sel = 2'b00;
    done_flag = 1'b0;
    case (state_q)
      ST_CLR: begin
        clk_ena = 1'b1;
        sclr_n  = 1'b0;
      end
      ST_LSB: begin
        clk_ena   = 1'b1;
        input_sel = 2'b00;
        shift_sel = 2'b00;
      end
      ST_MID: begin
        clk_ena   = 1'b1;
        input_sel = cnt_q ? 2'b10 : 2'b01;
        shift_sel = 2'b01;
      end
      ST_MSB: begin
        clk_ena   = 1'b1;
        input_sel = 2'b11;
        shift_sel = 2'b10;
      end
      ST_DONE: done_flag = 1'b1;
      default: ;
    endcase
  end

  assign state_out = state_q;

`ifdef MULT_CTRL_SEG_EN
  // Active-low gfedcba digit of the state code; illegal codes show "E".
  always_comb begin
    seg_out = 7'b0000110;
    case (state_q)
      3'd0:    seg_out = 7'b1000000;
      3'd1:    seg_out = 7'b1111001;
      3'd2:    seg_out = 7'b0100100;
      3'd3:    seg_out = 7'b0110000;
      3'd4:    seg_out = 7'b0011001;
      3'd5:    seg_out = 7'b0010010;
      default: seg_out = 7'b0000110;
    endcase
  end
`endif

endmodule

// File: tb/tb_mult_control.sv
module tb_mult_control;

  logic       clk = 1'b0;
  logic       reset_a;
  logic       start;
  logic       clk_ena, sclr_n, done_flag;
  logic [1:0] input_sel, shift_sel;
  logic [2:0] state_out;
`ifdef MULT_CTRL_SEG_EN
  logic [6:0] seg_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  a_op = 8'h00;
  logic [7:0]  b_op = 8'h00;
  logic [15:0] acc  = 16'h0000;
  logic        done_prev = 1'b0;

  // Behavioural model: position in the multiply sequence.
  // 0 = idle, 1 = clear, 2 = LSB, 3 = MID first, 4 = MID second, 5 = MSB, 6 = done
  int mstep = 0;
  int st_tab[7] = '{0, 1, 2, 3, 3, 4, 5};
  int in_tab[7] = '{0, 0, 0, 1, 2, 3, 0};
  int sh_tab[7] = '{0, 0, 0, 1, 1, 2, 0};
`ifdef MULT_CTRL_SEG_EN
  logic [6:0] seg_tab[8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000110, 7'b0000110};
`endif

  mult_control dut (
    .clk       (clk),
    .reset_a   (reset_a),
    .start     (start),
    .clk_ena   (clk_ena),
    .sclr_n    (sclr_n),
    .input_sel (input_sel),
    .shift_sel (shift_sel),
    .state_out (state_out),
    .done_flag (done_flag)
`ifdef MULT_CTRL_SEG_EN
    ,
    .seg_out   (seg_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of the sequence: start accepted in idle, five fixed steps, done
  // held while start stays high.
  always @(posedge clk or posedge reset_a) begin
    if (reset_a)           mstep <= 0;
    else if (mstep == 0)   mstep <= start ? 1 : 0;
    else if (mstep < 6)    mstep <= mstep + 1;
    else                   mstep <= start ? 6 : 0;
  end

  // Datapath stand-in: 4x4 multiplier, shifter and 16-bit accumulator driven
  // by the controller strobes. Not cleared by reset.
  function automatic logic [15:0] partial(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] isel, input logic [1:0] ssel);
    logic [15:0] na, nb, p;
    na = isel[0] ? {12'h0, a[7:4]} : {12'h0, a[3:0]};
    nb = isel[1] ? {12'h0, b[7:4]} : {12'h0, b[3:0]};
    p  = na * nb;
    case (ssel)
      2'b01:   return p << 4;
      2'b10:   return p << 8;
      default: return p;
    endcase
  endfunction

  always @(posedge clk) begin
    if (clk_ena) begin
      if (!sclr_n) acc <= 16'h0000;
      else         acc <= acc + partial(a_op, b_op, input_sel, shift_sel);
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_a) begin
      check("state_out", {29'b0, state_out}, st_tab[mstep]);
      check("clk_ena",   {31'b0, clk_ena},   (mstep >= 1 && mstep <= 5) ? 1 : 0);
      check("sclr_n",    {31'b0, sclr_n},    (mstep == 1) ? 0 : 1);
      check("done_flag", {31'b0, done_flag}, (mstep == 6) ? 1 : 0);
      if (mstep != 1) begin
        check("input_sel", {30'b0, input_sel}, in_tab[mstep]);
        check("shift_sel", {30'b0, shift_sel}, sh_tab[mstep]);
      end
`ifdef MULT_CTRL_SEG_EN
      check("seg_out", {25'b0, seg_out}, {25'b0, seg_tab[st_tab[mstep]]});
`endif
      if (done_flag && !done_prev)
        check("product", {16'b0, acc}, 16'(a_op) * 16'(b_op));
    end
    done_prev <= done_flag;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int exp_seq[6] = '{1, 2, 3, 3, 4, 5};
  int exp_in[6]  = '{0, 0, 1, 2, 3, 0};
  int exp_sh[6]  = '{0, 0, 1, 1, 2, 0};

  initial begin
    reset_a = 1'b1;
    start   = 1'b0;
    a_op    = 8'hFF;
    b_op    = 8'hFF;
    #2;
    check("rst_state",  {29'b0, state_out}, 0);
    check("rst_clk_ena", {31'b0, clk_ena},  0);
    check("rst_sclr_n", {31'b0, sclr_n},    1);
    check("rst_done",   {31'b0, done_flag}, 0);
    check("rst_sel",    {28'b0, input_sel, shift_sel}, 0);
    @(negedge clk);
    #1 reset_a = 1'b0;
    tick();
    tick();

    // Directed 0xFF * 0xFF with literal sequence expectations
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("seq_state", {29'b0, state_out}, exp_seq[i]);
      check("seq_clk_ena", {31'b0, clk_ena}, (i < 5) ? 1 : 0);
      check("seq_sclr_n", {31'b0, sclr_n}, (i == 0) ? 0 : 1);
      if (i > 0) begin
        check("seq_input_sel", {30'b0, input_sel}, exp_in[i]);
        check("seq_shift_sel", {30'b0, shift_sel}, exp_sh[i]);
      end
    end
    check("ff_done", {31'b0, done_flag}, 1);
    check("ff_product", {16'b0, acc}, 32'h0000FE01);

    // Start held high in DONE: no restart
    repeat (10) tick();
    check("hold_state", {29'b0, state_out}, 5);
    check("hold_done", {31'b0, done_flag}, 1);
    start = 1'b0;
    tick();
    check("drop_state", {29'b0, state_out}, 0);

    // Reset in the middle of a run, then a fresh 0x12 * 0x34
    a_op  = 8'h12;
    b_op  = 8'h34;
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    @(negedge clk);
    #1 reset_a = 1'b1;
    #1;
    check("abort_state", {29'b0, state_out}, 0);
    check("abort_clk_ena", {31'b0, clk_ena}, 0);
    @(negedge clk);
    #1 reset_a = 1'b0;
    tick();
    start = 1'b1;
    for (int k = 0; k < 20 && !done_flag; k++) tick();
    check("abort_done_reached", {31'b0, done_flag}, 1);
    check("abort_product", {16'b0, acc}, 32'h000003A8);
    start = 1'b0;
    tick();

    // Randomized runs: random operands, gaps, start noise mid-sequence,
    // DONE hold lengths and occasional aborting resets.
    for (int r = 0; r < 40; r++) begin
      a_op = 8'($urandom);
      b_op = 8'($urandom);
      repeat ($urandom_range(3)) tick();
      start = 1'b1;
      tick();
      if ($urandom_range(7) == 0) begin
        tick();
        @(negedge clk);
        #1 reset_a = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1 reset_a = 1'b0;
        tick();
      end else begin
        for (int s = 0; s < 4; s++) begin
          start = 1'($urandom);
          tick();
        end
        start = 1'b1;
        tick();
        check("rand_done", {31'b0, done_flag}, 1);
        repeat ($urandom_range(3)) tick();
        start = 1'b0;
        tick();
      end
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
